// File: rtl/aes_buffer_out_reader_pkg.sv
// Shared AES buffer definitions: word width, slot count, FSM state type
// and the block-size code decode used by both input and output buffers.
package aes_buffer_out_reader_pkg;

    localparam int WORD_W = 32;
    localparam int SLOTS  = 8;

    typedef enum logic {
        ST_FILL,
        ST_FULL
    } state_t;

    // bit3 wins (8 words), then bit2&bit1 (6 words); all else is 4 words
    function automatic logic [3:0] decode_block_size(input logic [3:0] code);
        logic [3:0] n;
        n = 4'd4;
        if (code[3]) begin
            n = 4'd8;
        end else if (code[2] && code[1]) begin
            n = 4'd6;
        end
        return n;
    endfunction

endpackage

// File: rtl/aes_blocksize_decode.sv
// Combinational block-size decoder.
// Ports: code (4-bit size code) -> n (words per block, 4/6/8).
module aes_blocksize_decode
    import aes_buffer_out_reader_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] n
);

    assign n = decode_block_size(code);

endmodule

// File: rtl/aes_buffer_out_reader.sv
// Pops N words from the AES output FIFO and presents them as one block
// until the host acknowledges it.
// Ports: iClk/iRst_n; iParam_load+iBlockSize set N and flush;
//   iFF_empty/oFF_read_req/iFF_data talk to a non-showahead FIFO;
//   oBlock_valid/oData_1..8/iBlock_ack present the block; oBlock_count
//   counts acknowledged blocks.
module aes_buffer_out_reader
    import aes_buffer_out_reader_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iParam_load,
    input  logic [3:0]        iBlockSize,
    input  logic              iFF_empty,
    output logic              oFF_read_req,
    input  logic [WORD_W-1:0] iFF_data,
    output logic              oBlock_valid,
    output logic [WORD_W-1:0] oData_1,
    output logic [WORD_W-1:0] oData_2,
    output logic [WORD_W-1:0] oData_3,
    output logic [WORD_W-1:0] oData_4,
    output logic [WORD_W-1:0] oData_5,
    output logic [WORD_W-1:0] oData_6,
    output logic [WORD_W-1:0] oData_7,
    output logic [WORD_W-1:0] oData_8,
    input  logic              iBlock_ack,
    output logic [15:0]       oBlock_count
);

    state_t            state;
    logic [3:0]        n_words;
    logic [3:0]        n_dec;
    logic [3:0]        issue_cnt;
    logic [3:0]        recv_cnt;
    logic              rd_pending;
    logic [WORD_W-1:0] word [SLOTS];

    aes_blocksize_decode u_decode (
        .code (iBlockSize),
        .n    (n_dec)
    );

    // Gated by iRst_n so no word is popped on an edge the block ignores
    assign oFF_read_req = iRst_n && (state == ST_FILL) && !iFF_empty &&
                          (issue_cnt != n_words) && !iParam_load;

    assign oData_1 = word[0];
    assign oData_2 = word[1];
    assign oData_3 = word[2];
    assign oData_4 = word[3];
    assign oData_5 = word[4];
    assign oData_6 = word[5];
    assign oData_7 = word[6];
    assign oData_8 = word[7];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= ST_FILL;
            n_words      <= 4'd4;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            rd_pending   <= 1'b0;
            oBlock_valid <= 1'b0;
            oBlock_count <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                word[i] <= '0;
            end
        end else if (iParam_load) begin
            // Flush drops any word still returning from the FIFO
            state        <= ST_FILL;
            n_words      <= n_dec;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            rd_pending   <= 1'b0;
            oBlock_valid <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                word[i] <= '0;
            end
        end else begin
            rd_pending <= oFF_read_req;
            case (state)
                ST_FILL: begin
                    if (oFF_read_req) begin
                        issue_cnt <= issue_cnt + 4'd1;
                    end
                    if (rd_pending) begin
                        word[recv_cnt[2:0]] <= iFF_data;
                        recv_cnt            <= recv_cnt + 4'd1;
                        if (recv_cnt == n_words - 4'd1) begin
                            state        <= ST_FULL;
                            oBlock_valid <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (iBlock_ack) begin
                        state        <= ST_FILL;
                        oBlock_valid <= 1'b0;
                        issue_cnt    <= '0;
                        recv_cnt     <= '0;
                        oBlock_count <= oBlock_count + 16'd1;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_buffer_out_reader.sv
// Directed testbench for aes_buffer_out_reader with a queue-based
// non-showahead FIFO model driven from the stimulus process.
module tb_aes_buffer_out_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        param_load;
    logic [3:0]  block_size;
    logic        ff_empty;
    logic        ff_rd;
    logic [31:0] ff_data;
    logic        valid;
    logic [31:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic        ack;
    logic [15:0] cnt;

    logic [31:0] fifo [$];
    logic        req_q;
    int          pops = 0;
    int          base = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    aes_buffer_out_reader dut (
        .iClk         (clk),
        .iRst_n       (rst_n),
        .iParam_load  (param_load),
        .iBlockSize   (block_size),
        .iFF_empty    (ff_empty),
        .oFF_read_req (ff_rd),
        .iFF_data     (ff_data),
        .oBlock_valid (valid),
        .oData_1      (d1),
        .oData_2      (d2),
        .oData_3      (d3),
        .oData_4      (d4),
        .oData_5      (d5),
        .oData_6      (d6),
        .oData_7      (d7),
        .oData_8      (d8),
        .iBlock_ack   (ack),
        .oBlock_count (cnt)
    );

    // Pre-edge value of the pop request
    always @(posedge clk) req_q <= ff_rd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: FIFO answers a pop with data after the edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (req_q) begin
            if (fifo.size() != 0) ff_data = fifo.pop_front();
            pops++;
        end
        ff_empty = (fifo.size() == 0);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        ff_empty = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic load(input logic [3:0] code);
        block_size = code;
        param_load = 1'b1;
        step();
        param_load = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        param_load = 1'b0;
        block_size = 4'd0;
        ff_empty   = 1'b1;
        ff_data    = '0;
        ack        = 1'b0;
        @(negedge clk);
        #1;
        step();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data1", d1, 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);

        // N=4 latency with a preloaded FIFO
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        step();
        chk("rst_no_pop", 32'(ff_rd), 32'd0);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("lat_req_c%0d", c), 32'(ff_rd), 32'(c < 4));
            chk($sformatf("lat_vld_c%0d", c), 32'(valid), 32'(c == 5));
            step();
        end
        chk("n4_d1", d1, 32'h11);
        chk("n4_d2", d2, 32'h22);
        chk("n4_d3", d3, 32'h33);
        chk("n4_d4", d4, 32'h44);
        chk("n4_d5", d5, 32'h0);
        chk("n4_d8", d8, 32'h0);
        pulse_ack();
        chk("n4_ack_vld", 32'(valid), 32'd0);
        chk("n4_ack_cnt", 32'(cnt), 32'd1);

        // N=8, nine words available, ack held low
        for (int i = 0; i < 9; i++) push(32'hA0 + 32'(i));
        load(4'b1000);
        base = pops;
        repeat (14) step();
        chk("n8_pops", 32'(pops - base), 32'd8);
        chk("n8_vld", 32'(valid), 32'd1);
        chk("n8_left", 32'(fifo.size()), 32'd1);
        chk("n8_d1", d1, 32'hA0);
        chk("n8_d8", d8, 32'hA7);
        repeat (3) step();
        chk("n8_hold", 32'(fifo.size()), 32'd1);
        chk("n8_hold_d5", d5, 32'hA4);
        pulse_ack();
        chk("n8_ack_cnt", 32'(cnt), 32'd2);
        repeat (3) step();
        chk("n8_ninth", 32'(fifo.size()), 32'd0);

        // N=6 with a FIFO stall after three words
        load(4'b0110);
        chk("n6_flush_d1", d1, 32'h0);
        push(32'hB0); push(32'hB1); push(32'hB2);
        repeat (8) step();
        chk("n6_stall_req", 32'(ff_rd), 32'd0);
        chk("n6_stall_vld", 32'(valid), 32'd0);
        chk("n6_stall_d3", d3, 32'hB2);
        chk("n6_stall_d4", d4, 32'h0);
        repeat (2) step();
        push(32'hB3); push(32'hB4); push(32'hB5);
        repeat (6) step();
        chk("n6_vld", 32'(valid), 32'd1);
        chk("n6_d1", d1, 32'hB0);
        chk("n6_d4", d4, 32'hB3);
        chk("n6_d6", d6, 32'hB5);
        chk("n6_d7", d7, 32'h0);
        pulse_ack();
        chk("n6_ack_cnt", 32'(cnt), 32'd3);

        // Reload right after the second pop drops the in-flight word
        push(32'hC0); push(32'hC1); push(32'hC2); push(32'hC3);
        load(4'b0100);
        step();
        step();
        load(4'b0110);
        chk("pl_d1", d1, 32'h0);
        chk("pl_vld", 32'(valid), 32'd0);
        chk("pl_left", 32'(fifo.size()), 32'd2);
        push(32'hD0); push(32'hD1); push(32'hD2); push(32'hD3);
        repeat (8) step();
        chk("pl_new_vld", 32'(valid), 32'd1);
        chk("pl_new_d1", d1, 32'hC2);
        chk("pl_new_d2", d2, 32'hC3);
        chk("pl_new_d3", d3, 32'hD0);
        chk("pl_new_d6", d6, 32'hD3);
        pulse_ack();
        chk("pl_ack_cnt", 32'(cnt), 32'd4);

        // Ack in FILL ignored, then reset mid-block
        pulse_ack();
        chk("fill_ack_cnt", 32'(cnt), 32'd4);
        chk("fill_ack_vld", 32'(valid), 32'd0);
        push(32'hE0); push(32'hE1);
        repeat (3) step();
        chk("part_d1", d1, 32'hE0);
        rst_n = 1'b0;
        #1;
        chk("mrst_d1", d1, 32'h0);
        chk("mrst_d2", d2, 32'h0);
        chk("mrst_cnt", 32'(cnt), 32'd0);
        chk("mrst_vld", 32'(valid), 32'd0);
        for (int i = 0; i < 5; i++) push(32'hF0 + 32'(i));
        step();
        base = pops;
        step();
        chk("mrst_no_pop", 32'(pops - base), 32'd0);
        rst_n = 1'b1;
        repeat (8) step();
        chk("mrst_n4_pops", 32'(pops - base), 32'd4);
        chk("mrst_n4_vld", 32'(valid), 32'd1);
        chk("mrst_n4_d1", d1, 32'hF0);
        chk("mrst_n4_d4", d4, 32'hF3);
        chk("mrst_n4_d5", d5, 32'h0);
        pulse_ack();
        chk("mrst_ack_cnt", 32'(cnt), 32'd1);

        // Block counter wraps after 16'hFFFF
        force dut.oBlock_count = 16'hFFFF;
        #1;
        release dut.oBlock_count;
        #1;
        chk("wrap_pre", 32'(cnt), 32'hFFFF);
        push(32'h61); push(32'h62); push(32'h63);
        repeat (8) step();
        chk("wrap_vld", 32'(valid), 32'd1);
        chk("wrap_d1", d1, 32'hF4);
        pulse_ack();
        chk("wrap_cnt", 32'(cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
